ahbl_bus_n: RTL and testbench

Parametrised AHB-Lite single-master interconnect: address decoder plus data-phase response multiplexer for NSLV slaves. It is the generalised successor to the fixed six-slave bus in the AHB subsystem.

---
 rtl/ahbl_bus_n.sv | 130 +++++++++++++
 tb/tb_ahbl_bus_n.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ahbl_bus_n.sv
// AHB-Lite single-master interconnect: page decoder, data-phase response mux,
// built-in default (ERROR) slave and a wait-state watchdog that aborts hung slaves.
module ahbl_bus_n #(
  parameter int NSLV     = 6,
  parameter int DEC_HI   = 31,
  parameter int DEC_LO   = 24,
  parameter int SLV_BASE = 'h40,
  parameter int TIMEOUT  = 255
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic [31:0]          HADDR,
  input  logic [1:0]           HTRANS,
  output logic                 HREADY,
  output logic [31:0]          HRDATA,
  output logic                 HRESP,
  output logic [NSLV-1:0]      HSEL_S,
  input  logic [NSLV-1:0]      HREADY_S,
  input  logic [32*NSLV-1:0]   HRDATA_S,
  input  logic [NSLV-1:0]      HRESP_S,
  input  logic                 tmo_clr,
  output logic                 tmo_irq,
  output logic [3:0]           tmo_slave
);

  localparam int DW  = DEC_HI - DEC_LO + 1;
  localparam int WCW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCW-1:0] TMO_V = WCW'(TIMEOUT);

  // ERR1/ERR2 are the two cycles of an ERROR response, shared by the
  // default slave and the watchdog abort.
  typedef enum logic [1:0] {D_NONE, D_SLV, D_ERR1, D_ERR2} dsel_e;

  dsel_e            st_q, st_d;
  logic [3:0]       idx_q, idx_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             irq_q, irq_d;
  logic [3:0]       tslv_q, tslv_d;

  logic [DW-1:0]    page;
  logic             hit;
  logic [3:0]       hit_idx;
  logic             sel_rdy, sel_resp;
  logic [31:0]      sel_data;
  logic             wd_fire;
  logic             unused;

  assign page   = HADDR[DEC_HI:DEC_LO];
  assign unused = ^{HADDR, HTRANS[0]};

  for (genvar g = 0; g < NSLV; g++) begin : g_dec
    assign HSEL_S[g] = (page == DW'(SLV_BASE + g));
  end

  assign hit = |HSEL_S;

  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NSLV; i++)
      if (HSEL_S[i]) hit_idx = 4'(i);
  end

  always_comb begin
    sel_rdy  = 1'b1;
    sel_resp = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NSLV; i++)
      if (idx_q == 4'(i)) begin
        sel_rdy  = HREADY_S[i];
        sel_resp = HRESP_S[i];
        sel_data = HRDATA_S[32*i +: 32];
      end
  end

  // Fires on the wait cycle that would bring the count to TIMEOUT, so the
  // ERROR starts right after exactly TIMEOUT wait states.
  assign wd_fire = (TIMEOUT != 0) && (st_q == D_SLV) && !sel_rdy &&
                   (wcnt_q == TMO_V - WCW'(1));

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    case (st_q)
      D_SLV:  begin HREADY = sel_rdy; HRESP = sel_resp; HRDATA = sel_data; end
      D_ERR1: begin HREADY = 1'b0;    HRESP = 1'b1; end
      D_ERR2: begin HRESP  = 1'b1; end
      default: ;
    endcase

    st_d   = st_q;
    idx_d  = idx_q;
    wcnt_d = '0;
    irq_d  = irq_q & ~tmo_clr;
    tslv_d = tslv_q;
    if (st_q == D_ERR1) begin
      st_d = D_ERR2;
    end else if (wd_fire) begin
      st_d   = D_ERR1;
      irq_d  = 1'b1;
      tslv_d = idx_q;
    end else if (HREADY) begin
      if (!HTRANS[1])  st_d = D_NONE;
      else if (hit)    begin st_d = D_SLV; idx_d = hit_idx; end
      else             st_d = D_ERR1;
    end else if (TIMEOUT != 0) begin
      wcnt_d = wcnt_q + WCW'(1);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_q   <= D_NONE;
      idx_q  <= '0;
      wcnt_q <= '0;
      irq_q  <= 1'b0;
      tslv_q <= '0;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      wcnt_q <= wcnt_d;
      irq_q  <= irq_d;
      tslv_q <= tslv_d;
    end
  end

  assign tmo_irq   = irq_q;
  assign tmo_slave = tslv_q;

endmodule

// File: tb/tb_ahbl_bus_n.sv
// Randomized bench for ahbl_bus_n against a transfer-level reference model.
module tb_ahbl_bus_n;
  localparam int NSLV = 6;
  localparam int TMO  = 4;
  localparam int NCYC = 3000;

  logic                HCLK = 1'b0;
  logic                HRESETn;
  logic [31:0]         HADDR;
  logic [1:0]          HTRANS;
  logic                HREADY, HRESP, tmo_clr, tmo_irq;
  logic [31:0]         HRDATA;
  logic [NSLV-1:0]     HSEL_S, HREADY_S, HRESP_S;
  logic [32*NSLV-1:0]  HRDATA_S;
  logic [3:0]          tmo_slave;

  ahbl_bus_n #(.NSLV(NSLV), .DEC_HI(31), .DEC_LO(24), .SLV_BASE('h40), .TIMEOUT(TMO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS),
    .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP), .HSEL_S(HSEL_S),
    .HREADY_S(HREADY_S), .HRDATA_S(HRDATA_S), .HRESP_S(HRESP_S),
    .tmo_clr(tmo_clr), .tmo_irq(tmo_irq), .tmo_slave(tmo_slave)
  );

  always #5 HCLK = ~HCLK;

  int nvec = 0, nerr = 0;

  // transfer model: tgt -1 none, -2 default slave, else slave index
  int tgt, errc, waits, tslv;
  bit irq;
  logic [NSLV-1:0] hang;

  logic        e_rdy, e_resp;
  logic [31:0] e_data;
  logic [NSLV-1:0] e_sel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int page_of(input logic [31:0] a);
    return int'(a[31:24]);
  endfunction

  task automatic drive();
    int r;
    logic [31:0] tmp;
    logic [7:0]  pg;
    r = $urandom_range(0, 9);
    if (r < 6)       pg = 8'(8'h40 + r);
    else if (r == 6) pg = 8'h46;
    else if (r == 7) pg = 8'h3F;
    else begin tmp = $urandom(); pg = tmp[7:0]; end
    tmp   = $urandom();
    HADDR = {pg, tmp[23:0]};
    r = $urandom_range(0, 7);
    HTRANS = (r < 4) ? 2'b10 : (r == 4) ? 2'b11 : (r == 5) ? 2'b01 : 2'b00;
    for (int i = 0; i < NSLV; i++) begin
      HREADY_S[i] = hang[i] ? 1'b0 : ($urandom_range(0, 9) < 7);
      HRESP_S[i]  = ($urandom_range(0, 7) == 0);
      HRDATA_S[32*i +: 32] = $urandom();
    end
    tmo_clr = ($urandom_range(0, 15) == 0);
    // aim some clears at the exact cycle a timeout fires
    if (tgt >= 0 && errc == 0 && waits == TMO-1 && !HREADY_S[tgt])
      tmo_clr = ($urandom_range(0, 1) == 1);
  endtask

  task automatic expect_now();
    int p;
    p = page_of(HADDR);
    e_sel = (p >= 'h40 && p < 'h40 + NSLV) ? NSLV'(1 << (p - 'h40)) : '0;
    e_data = '0;
    if (errc == 1)      begin e_rdy = 1'b0; e_resp = 1'b1; end
    else if (errc == 2) begin e_rdy = 1'b1; e_resp = 1'b1; end
    else if (tgt < 0)   begin e_rdy = 1'b1; e_resp = 1'b0; end
    else begin
      e_rdy  = HREADY_S[tgt];
      e_resp = HRESP_S[tgt];
      e_data = HRDATA_S[32*tgt +: 32];
    end
  endtask

  task automatic check_all();
    expect_now();
    chk("hready", HREADY, e_rdy);
    chk("hresp", HRESP, e_resp);
    chk("hrdata", HRDATA, e_data);
    chk("hsel", HSEL_S, e_sel);
    chk("tmo_irq", tmo_irq, irq);
    chk("tmo_slave", tmo_slave, tslv);
  endtask

  task automatic model_clock();
    int p;
    if (tmo_clr) irq = 1'b0;
    if (errc == 1) errc = 2;
    else if (tgt >= 0 && errc == 0 && !HREADY_S[tgt]) begin
      waits++;
      if (waits == TMO) begin errc = 1; irq = 1'b1; tslv = tgt; waits = 0; end
    end else begin
      errc = 0; waits = 0;
      p = page_of(HADDR);
      if (!HTRANS[1])                        tgt = -1;
      else if (p >= 'h40 && p < 'h40 + NSLV) tgt = p - 'h40;
      else begin tgt = -2; errc = 1; end
    end
  endtask

  task automatic model_reset();
    tgt = -1; errc = 0; waits = 0; irq = 1'b0; tslv = 0;
  endtask

  initial begin
    bit rst_done = 0;
    model_reset();
    hang = '0;
    HRESETn = 1'b0; HADDR = '0; HTRANS = 2'b00; tmo_clr = 1'b0;
    HREADY_S = '1; HRESP_S = '0; HRDATA_S = '0;
    #12;
    chk("rst_hready", HREADY, 1'b1);
    chk("rst_hresp", HRESP, 1'b0);
    chk("rst_hrdata", HRDATA, 32'h0);
    chk("rst_irq", tmo_irq, 1'b0);
    chk("rst_tslv", tmo_slave, 4'h0);
    @(negedge HCLK); HRESETn = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      if (cyc % 48 == 0)
        hang = ($urandom_range(0, 2) == 0) ? NSLV'(1 << $urandom_range(0, NSLV-1)) : '0;
      @(negedge HCLK);
      drive();
      #1 check_all();
      if (!rst_done && cyc > 300 && errc == 1 && tgt == -2) begin
        #1 HRESETn = 1'b0;
        #1;
        chk("arst_hready", HREADY, 1'b1);
        chk("arst_hresp", HRESP, 1'b0);
        chk("arst_irq", tmo_irq, 1'b0);
        model_reset();
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
        rst_done = 1;
        continue;
      end
      @(posedge HCLK);
      model_clock();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
